// File: rtl/mmu_init_ctrl.sv
// mmu_init_ctrl: fills the 256-entry MMU RAM after reset/START and optionally verifies it
// Clocking: CLKX4 system clock; E is the CPU E clock, each phase 2 CLKX4 cycles; nRESET async active-low.
// Ports:
//   START              one-cycle re-initialise request, honoured only when idle
//   FILL               init value for entries with address[7:3] != 0 (entries 0..7 map to 0..7)
//   CPU_*              CPU-side MMU RAM lookup/write path, passed through whenever the engine is off the bus
//   MMU_* / MMU_DIN    MMU RAM bus
//   BUSY / DONE / ERR  init in progress / init complete (sticky) / verify mismatch (sticky)
// Build option: define MMU_INIT_VERIFY_EN to add the read-back verify pass and a functional ERR.
module mmu_init_ctrl (
  input  logic       CLKX4,
  input  logic       nRESET,
  input  logic       E,
  input  logic       START,
  input  logic [7:0] FILL,
  input  logic [7:0] CPU_ADDR,
  input  logic       CPU_nRD,
  input  logic       CPU_nWR,
  input  logic [7:0] CPU_DOUT,
  input  logic       CPU_DOE,
  output logic [7:0] MMU_ADDR,
  output logic       MMU_nRD,
  output logic       MMU_nWR,
  output logic [7:0] MMU_DOUT,
  output logic       MMU_DOE,
  input  logic [7:0] MMU_DIN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);
`ifdef MMU_INIT_VERIFY_EN
  typedef enum logic [1:0] {WR, VF, IDLE} state_t;
  logic err, err_n;
`else
  typedef enum logic [1:0] {WR, IDLE} state_t;
`endif
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, init_val;
  logic e_q, s0_q, done, done_n, slot0, slot1, eng, wr;
  // slot0 is the first CLKX4 cycle of E low; slot1 needs E still low, so a short E dip never writes
  assign slot0 = ~E & e_q;
  assign slot1 = ~E & s0_q;
  assign init_val = (cnt[7:3] == 5'd0) ? {5'd0, cnt[2:0]} : FILL;
  assign eng = (state != IDLE) & (slot0 | slot1);
  assign wr = (state == WR);
  assign BUSY = (state != IDLE);
  assign DONE = done;
  // reset gating keeps strobes inactive the instant nRESET falls, cutting any write pulse short
  assign MMU_ADDR = eng ? cnt : CPU_ADDR;
  assign MMU_DOUT = eng ? init_val : CPU_DOUT;
  assign MMU_DOE = nRESET & (eng ? wr : CPU_DOE);
  assign MMU_nRD = ~nRESET | (eng ? wr : CPU_nRD);
  assign MMU_nWR = ~nRESET | (eng ? ~(wr & slot1) : CPU_nWR);
  always_ff @(posedge CLKX4 or negedge nRESET)
    if (!nRESET) begin
      state <= WR;
      cnt <= '0;
      e_q <= 1'b1;
      s0_q <= 1'b0;
      done <= 1'b0;
`ifdef MMU_INIT_VERIFY_EN
      err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      e_q <= E;
      s0_q <= slot0;
      done <= done_n;
`ifdef MMU_INIT_VERIFY_EN
      err <= err_n;
`endif
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    done_n = done;
`ifdef MMU_INIT_VERIFY_EN
    err_n = err;
`endif
    case (state)
      IDLE: if (START) begin
        state_n = WR;
        cnt_n = '0;
        done_n = 1'b0;
`ifdef MMU_INIT_VERIFY_EN
        err_n = 1'b0;
`endif
      end
      WR: if (slot1) begin
        cnt_n = cnt + 8'd1;
        if (&cnt) begin
`ifdef MMU_INIT_VERIFY_EN
          state_n = VF;
`else
          state_n = IDLE;
          done_n = 1'b1;
`endif
        end
      end
`ifdef MMU_INIT_VERIFY_EN
      VF: if (slot1) begin
        cnt_n = cnt + 8'd1;
        err_n = err | (MMU_DIN != init_val);
        if (&cnt) begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end
`ifdef MMU_INIT_VERIFY_EN
  assign ERR = err;
`else
  logic unused_din;
  assign unused_din = ^MMU_DIN;
  assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_mmu_init_ctrl.sv
// tb_mmu_init_ctrl: directed bench for mmu_init_ctrl against a 256-entry model RAM
module tb_mmu_init_ctrl;
  logic CLKX4 = 1'b0, nRESET = 1'b1, E = 1'b1, START = 1'b0;
  logic [7:0] FILL = 8'hC0, CPU_ADDR = 8'h00, CPU_DOUT = 8'h00;
  logic CPU_nRD = 1'b1, CPU_nWR = 1'b1, CPU_DOE = 1'b0;
  logic [7:0] MMU_ADDR, MMU_DOUT, MMU_DIN;
  logic MMU_nRD, MMU_nWR, MMU_DOE, BUSY, DONE, ERR;
  logic [7:0] ram [256];
  logic force_2a = 1'b1;
  int wr_cnt = 0, tests = 0, fails = 0, base, bad;
  mmu_init_ctrl dut (
    .CLKX4(CLKX4), .nRESET(nRESET), .E(E), .START(START), .FILL(FILL),
    .CPU_ADDR(CPU_ADDR), .CPU_nRD(CPU_nRD), .CPU_nWR(CPU_nWR), .CPU_DOUT(CPU_DOUT), .CPU_DOE(CPU_DOE),
    .MMU_ADDR(MMU_ADDR), .MMU_nRD(MMU_nRD), .MMU_nWR(MMU_nWR), .MMU_DOUT(MMU_DOUT), .MMU_DOE(MMU_DOE),
    .MMU_DIN(MMU_DIN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );
  always #5 CLKX4 = ~CLKX4;
  always @(posedge CLKX4)
    if (nRESET && !MMU_nWR) begin
      ram[MMU_ADDR] <= MMU_DOUT;
      wr_cnt <= wr_cnt + 1;
    end
  assign MMU_DIN = (force_2a && MMU_ADDR == 8'h2A) ? 8'h00 : ram[MMU_ADDR];
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge CLKX4);
    #1;
  endtask
  task automatic slot0();
    E = 1'b1;
    tick();
    tick();
    E = 1'b0;
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      slot0();
      tick();
      tick();
    end
  endtask
  initial begin
    CPU_nWR = 1'b0;
    CPU_DOE = 1'b1;
    CPU_nRD = 1'b0;
    #1 nRESET = 1'b0;
    #1;
    chk("rst_busy", 8'(BUSY), 8'd1);
    chk("rst_done", 8'(DONE), 8'd0);
    chk("rst_err", 8'(ERR), 8'd0);
    chk("rst_nwr", 8'(MMU_nWR), 8'd1);
    chk("rst_nrd", 8'(MMU_nRD), 8'd1);
    chk("rst_doe", 8'(MMU_DOE), 8'd0);
    CPU_nWR = 1'b1;
    CPU_DOE = 1'b0;
    CPU_nRD = 1'b1;
    tick();
    tick();
    nRESET = 1'b1;
    tick();
    slot0();
    chk("e0_s0_addr", MMU_ADDR, 8'h00);
    chk("e0_s0_doe", 8'(MMU_DOE), 8'd1);
    chk("e0_s0_nwr", 8'(MMU_nWR), 8'd1);
    chk("e0_s0_dout", MMU_DOUT, 8'h00);
    tick();
    chk("e0_s1_nwr", 8'(MMU_nWR), 8'd0);
    chk("e0_s1_addr", MMU_ADDR, 8'h00);
    tick();
    run(7);
    slot0();
    chk("e8_addr", MMU_ADDR, 8'h08);
    chk("e8_dout", MMU_DOUT, 8'hC0);
    tick();
    tick();
    run(13);
    E = 1'b1;
    CPU_nRD = 1'b0;
    CPU_ADDR = 8'h15;
    tick();
    chk("cpu_addr", MMU_ADDR, 8'h15);
    chk("cpu_nwr", 8'(MMU_nWR), 8'd1);
    chk("cpu_nrd", 8'(MMU_nRD), 8'd0);
    tick();
    E = 1'b0;
    #1;
    chk("cpu_back_addr", MMU_ADDR, 8'h16);
    chk("cpu_back_nrd", 8'(MMU_nRD), 8'd1);
    tick();
    tick();
    CPU_nRD = 1'b1;
    run(41);
    E = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    E = 1'b0;
    #1;
    chk("start_busy_addr", MMU_ADDR, 8'h40);
    chk("start_busy", 8'(BUSY), 8'd1);
    tick();
    tick();
    E = 1'b1;
    tick();
    tick();
    E = 1'b0;
    tick();
    E = 1'b1;
    #1;
    chk("glitch_nwr", 8'(MMU_nWR), 8'd1);
    tick();
    tick();
    slot0();
    chk("glitch_addr", MMU_ADDR, 8'h41);
    tick();
    tick();
    run(189);
    chk("pre_done", 8'(DONE), 8'd0);
    run(1);
`ifdef MMU_INIT_VERIFY_EN
    chk("wr_end_done", 8'(DONE), 8'd0);
    chk("wr_end_busy", 8'(BUSY), 8'd1);
    run(42);
    chk("err_before_2a", 8'(ERR), 8'd0);
    run(1);
    chk("err_at_2a", 8'(ERR), 8'd1);
    run(213);
    chk("end_err", 8'(ERR), 8'd1);
`else
    chk("end_err", 8'(ERR), 8'd0);
`endif
    chk("end_done", 8'(DONE), 8'd1);
    chk("end_busy", 8'(BUSY), 8'd0);
    chk("wr_count", 8'(wr_cnt), 8'd0);
    chk("wr_count_hi", 8'(wr_cnt >> 8), 8'd1);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (ram[i] !== ((i < 8) ? 8'(i) : 8'hC0)) bad++;
    chk("ram_bad", 8'(bad), 8'd0);
    chk("ram7", ram[7], 8'h07);
    chk("ram8", ram[8], 8'hC0);
    CPU_nWR = 1'b0;
    CPU_DOE = 1'b1;
    CPU_DOUT = 8'h55;
    CPU_ADDR = 8'h90;
    #1;
    chk("idle_nwr", 8'(MMU_nWR), 8'd0);
    chk("idle_doe", 8'(MMU_DOE), 8'd1);
    chk("idle_dout", MMU_DOUT, 8'h55);
    chk("idle_addr", MMU_ADDR, 8'h90);
    tick();
    CPU_nWR = 1'b1;
    CPU_DOE = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("restart_busy", 8'(BUSY), 8'd1);
    chk("restart_done", 8'(DONE), 8'd0);
    chk("restart_err", 8'(ERR), 8'd0);
    slot0();
    chk("restart_addr", MMU_ADDR, 8'h00);
    tick();
    tick();
    run(127);
    slot0();
    tick();
    chk("e80_nwr", 8'(MMU_nWR), 8'd0);
    chk("e80_addr", MMU_ADDR, 8'h80);
    nRESET = 1'b0;
    #1;
    chk("abort_nwr", 8'(MMU_nWR), 8'd1);
    chk("abort_busy", 8'(BUSY), 8'd1);
    tick();
    E = 1'b1;
    nRESET = 1'b1;
    base = wr_cnt;
    slot0();
    tick();
    chk("after_rst_addr", MMU_ADDR, 8'h00);
    chk("after_rst_nwr", 8'(MMU_nWR), 8'd0);
    tick();
    chk("after_rst_writes", 8'(wr_cnt - base), 8'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmu_init_ctrl.md
MMU_INIT_CTRL -- requirements
Module: mmu_init_ctrl

Interface
REQ-001 SHALL have port CLKX4  in  1  system clock; E phases are derived from it, each E phase is 2 CLKX4 cycles.
REQ-002 SHALL have port nRESET  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port E  in  1  CPU E clock, synchronous to CLKX4.
REQ-004 SHALL have port START  in  1  one-cycle re-initialise request.
REQ-005 SHALL have port FILL  in  8  init value for entries with address[7:3] != 0.
REQ-006 SHALL have ports CPU_ADDR in 8, CPU_nRD in 1, CPU_nWR in 1, CPU_DOUT in 8, CPU_DOE in 1: the CPU-side MMU RAM lookup/write path.
REQ-007 SHALL have ports MMU_ADDR out 8, MMU_nRD out 1, MMU_nWR out 1, MMU_DOUT out 8, MMU_DOE out 1, MMU_DIN in 8: the MMU RAM bus.
REQ-008 SHALL have ports BUSY out 1 (init in progress), DONE out 1 (init complete, sticky) and ERR out 1 (verify mismatch, sticky).

Function
REQ-009 SHALL register E into e_q each CLKX4 cycle; slot0 = (E==0 && e_q==1); slot1 = the CLKX4 cycle after slot0.
REQ-010 SHALL have a state machine with states WR, VF and IDLE, plus an 8-bit entry counter cnt.
REQ-011 In WR, during slot0 the block SHALL drive MMU_ADDR=cnt, MMU_DOUT=initval(cnt), MMU_DOE=1, MMU_nWR=1, MMU_nRD=1.
REQ-012 In WR, during slot1 the block SHALL drive the same address and data with MMU_nWR=0, then increment cnt.
REQ-013 initval(a) SHALL be {5'b0, a[2:0]} when a[7:3]==0 (task 0 identity map), and FILL otherwise.
REQ-014 When cnt wraps 255->0 at the end of a WR slot1, the state SHALL go to VF if verify is compiled in, else to IDLE.
REQ-015 In VF, during slot0 the block SHALL drive MMU_ADDR=cnt, MMU_nRD=0, MMU_nWR=1, MMU_DOE=0.
REQ-016 In VF, during slot1 the block SHALL keep the same drive, compare MMU_DIN against initval(cnt), set ERR on mismatch, and increment cnt; the wrap 255->0 SHALL go to IDLE.
REQ-017 Entering IDLE SHALL set DONE=1 and BUSY=0; BUSY SHALL be 1 in WR and VF.
REQ-018 Outside engine slots (E high, or state IDLE), the MMU_* outputs SHALL equal the corresponding CPU_* inputs combinationally.
REQ-019 Whenever E==1, the CPU SHALL own the bus; the engine SHALL never drive during E high.
REQ-020 START in IDLE SHALL cause, on the next cycle: WR, cnt=0, DONE=0, ERR=0.
REQ-021 START in WR or VF SHALL be ignored.
REQ-022 A CPU write during E high while BUSY SHALL pass through; the entry MAY later be overwritten by the engine or flagged by verify.
REQ-023 An FSM transition SHALL only occur at slot1; slot0 without a following slot1 (E glitch) SHALL NOT advance cnt.
REQ-024 One full write pass SHALL take exactly 256 E cycles; with verify, the total SHALL be 512 E cycles.

Reset
REQ-025 Asynchronous nRESET low SHALL force: state=WR, cnt=0, e_q=1, BUSY=1, DONE=0, ERR=0, MMU_nWR=1, MMU_nRD=1, MMU_DOE=0.
REQ-026 After nRESET deasserts, initialisation SHALL start automatically at the first slot0.
REQ-027 Reset asserted mid-pass SHALL abort the pass and restart from entry 0; no partial MMU_nWR pulse SHALL survive (MMU_nWR returns high asynchronously).

Configuration
REQ-028 Macro MMU_INIT_VERIFY_EN defined: VF state and compare logic SHALL be present and ERR SHALL be functional.
REQ-029 Macro MMU_INIT_VERIFY_EN undefined: VF SHALL be absent, WR wrap SHALL go directly to IDLE, ERR SHALL be tied 0 and MMU_DIN unused.

Verification
REQ-030 Reset release, FILL=8'hC0, model RAM -> 256 writes; RAM[0..7]=0..7, RAM[8..255]=8'hC0; DONE=1 after 256 E cycles (no verify) or 512 E cycles (verify).
REQ-031 Verify build, model RAM forces RAM[8'h2A] to read 8'h00 -> ERR=1 at entry 2A slot1; pass continues; DONE=1 at end.
REQ-032 START pulse while BUSY (at cnt=8'h40) -> no restart; START after DONE -> BUSY=1, DONE=0, ERR=0, writes restart at address 0.
REQ-033 CPU_nRD=0, CPU_ADDR=8'h15 during E high while BUSY -> MMU_ADDR=8'h15, MMU_nWR=1; at the next slot0 MMU_ADDR returns to cnt.
REQ-034 nRESET pulsed low during slot1 of entry 8'h80 -> MMU_nWR high immediately; after release, first write targets address 0.
REQ-035 Idle pass-through: CPU_nWR=0, CPU_DOE=1, CPU_DOUT=8'h55 -> MMU_nWR=0, MMU_DOE=1, MMU_DOUT=8'h55 in the same cycle.
